// File: rtl/switch_input_conditioner_if.sv
// Switch-conditioner bus: raw switch levels and event clear in; debounced
// levels, change flags and priority-encoded operation select out.
interface switch_input_conditioner_if;
  logic [6:0] sw_raw;
  logic       evt_clr;
  logic       swinit;
  logic       swadd;
  logic       swnot;
  logic       swxor;
  logic       swxor0;
  logic       swxor1;
  logic       swxor2;
  logic       sw_changed;
  logic       sw_event;
  logic [2:0] op_sel;
  logic       op_valid;

  modport master (
    output sw_raw, evt_clr,
    input  swinit, swadd, swnot, swxor, swxor0, swxor1, swxor2,
    input  sw_changed, sw_event, op_sel, op_valid
  );

  modport slave (
    input  sw_raw, evt_clr,
    output swinit, swadd, swnot, swxor, swxor0, swxor1, swxor2,
    output sw_changed, sw_event, op_sel, op_valid
  );
endinterface

// File: rtl/switch_input_conditioner.sv
// Conditions seven raw board switches: two-flop synchroniser, per-bit counter
// debouncer, change pulse, sticky change flag and priority-encoded select.
module switch_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  switch_input_conditioner_if.slave    bus
);
  localparam int unsigned N_SW  = 7;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sync1;
  logic [N_SW-1:0]  sync2;
  logic [N_SW-1:0]  deb;
  logic [N_SW-1:0]  deb_nxt;
  logic [CNT_W-1:0] cnt     [N_SW];
  logic [CNT_W-1:0] cnt_nxt [N_SW];
  logic             toggle;
  logic             changed;
  logic             event_flag;
  logic [2:0]       op_sel_c;

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < N_SW; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CNT_MAX) begin
          deb_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign toggle = |(deb ^ deb_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      changed    <= 1'b0;
      event_flag <= 1'b0;
      for (int i = 0; i < N_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= bus.sw_raw;
      sync2      <= sync1;
      deb        <= deb_nxt;
      changed    <= toggle;
      // A new toggle outranks a concurrent clear so no change is ever lost.
      event_flag <= toggle | (event_flag & ~bus.evt_clr);
      for (int i = 0; i < N_SW; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Highest set debounced bit wins; bit 6 has top priority.
  always_comb begin
    op_sel_c = 3'd0;
    casez (deb)
      7'b1??????: op_sel_c = 3'd6;
      7'b01?????: op_sel_c = 3'd5;
      7'b001????: op_sel_c = 3'd4;
      7'b0001???: op_sel_c = 3'd3;
      7'b00001??: op_sel_c = 3'd2;
      7'b000001?: op_sel_c = 3'd1;
      default:    op_sel_c = 3'd0;
    endcase
  end

  assign bus.swinit     = deb[0];
  assign bus.swadd      = deb[1];
  assign bus.swnot      = deb[2];
  assign bus.swxor      = deb[3];
  assign bus.swxor0     = deb[4];
  assign bus.swxor1     = deb[5];
  assign bus.swxor2     = deb[6];
  assign bus.sw_changed = changed;
  assign bus.sw_event   = event_flag;
  assign bus.op_sel     = op_sel_c;
  assign bus.op_valid   = |deb;
endmodule

// File: doc/switch_input_conditioner.md
Name: switch_input_conditioner

Overview:
- Sits directly upstream of the memory-management block. Conditions the seven raw board switches and drives its swinit/swadd/swnot/swxor/swxor0/swxor1/swxor2 inputs.
- Per switch: a two-flop synchroniser, then a counter-based debouncer.
- Also produces a one-cycle change pulse, a sticky change flag, and a priority-encoded operation select, so software can poll the switch state through memory-mapped reads.

Parameters:
- N_SW, 7: number of switches. Fixed at 7 for this design; the port list assumes 7.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised level must differ from the debounced level before it is accepted. Legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of each debounce counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  7  asynchronous switch levels. Bit mapping: [0] init, [1] add, [2] not, [3] xor, [4] xor0, [5] xor1, [6] xor2.
- evt_clr  in  1  clears sw_event.
- swinit  out  1  debounced sw_raw[0].
- swadd  out  1  debounced sw_raw[1].
- swnot  out  1  debounced sw_raw[2].
- swxor  out  1  debounced sw_raw[3].
- swxor0  out  1  debounced sw_raw[4].
- swxor1  out  1  debounced sw_raw[5].
- swxor2  out  1  debounced sw_raw[6].
- sw_changed  out  1  one-cycle pulse after any debounced bit changes.
- sw_event  out  1  sticky flag: some debounced bit has changed since the last clear.
- op_sel  out  3  index of the highest asserted debounced bit; bit 6 has highest priority.
- op_valid  out  1  at least one debounced bit is 1.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Both synchroniser stages, all debounced bits and all counters go to 0.
  - sw_changed=0, sw_event=0, op_sel=0, op_valid=0.
  - Reset mid-debounce discards the pending count; reset wins over every other event.
- Synchroniser: sync1<=sw_raw, then sync2<=sync1. sync2 is the only value the debouncer uses.
- Debounce, per bit i, evaluated each edge:
  - sync2[i]==deb[i]: cnt[i]<=0.
  - sync2[i]!=deb[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
  - sync2[i]!=deb[i] and cnt[i]==DEBOUNCE_CYCLES-1: deb[i]<=sync2[i] and cnt[i]<=0.
- Latency: a clean, held raw transition appears on the debounced output at rising edge DEBOUNCE_CYCLES+2 after the edge that first samples it. With the default of 16 this is 18 edges.
- Glitch rejection: a raw pulse whose synchronised width is shorter than DEBOUNCE_CYCLES cycles resets the counter and leaves the output unchanged. Bouncing restarts the count from 0.
- Bits are independent: simultaneous transitions on several bits each complete on their own schedule.
- sw_changed:
  - Registered; =1 for exactly one cycle following any edge at which at least one deb bit toggled.
  - Several bits toggling on the same edge give one pulse.
  - Toggles on consecutive edges give a pulse on each.
- sw_event:
  - Set by the same toggle condition.
  - Cleared when evt_clr=1 at an edge.
  - Simultaneous set and clear: set wins, sw_event stays 1.
- op_sel / op_valid:
  - Combinational from the debounced register, so they carry no extra latency beyond the debounced bits.
  - op_sel = highest index i with deb[i]=1. Example: swxor2 and swadd both set gives op_sel=6.
  - All debounced bits 0: op_valid=0, op_sel=0.
- Debounced outputs are glitch-free register outputs and are never driven straight from sw_raw.

Test Plan:
- Reset with sw_raw=7'h7F held for 5 cycles, then release rst: all outputs 0 at release. swinit..swxor2=1 exactly 18 edges after release. sw_changed pulses once on the next cycle. op_sel=6, op_valid=1.
- Bounce on sw_raw[1]: 0→1 for 5 cycles, 0 for 3 cycles, then 1 held. swadd stays 0 through the bounce and rises 18 edges after the final 0→1. Only one sw_changed pulse.
- Glitch: sw_raw[3] high for DEBOUNCE_CYCLES-1 = 15 cycles, then low. swxor, sw_changed and sw_event all remain 0.
- sw_event handling: after a debounced change, sw_event=1. Assert evt_clr for 1 cycle: sw_event=0. Assert evt_clr on the same edge as a new toggle: sw_event stays 1.
- Priority encoding: sequentially debounce sw_raw=7'b0000100, then 7'b0010100, then 7'b0000000. Expect op_sel=2, then 4, then 0 with op_valid=0.
- Reset mid-operation: sw_raw[6] rises and rst is pulsed 10 cycles later (count pending). swxor2 stays 0. Counting restarts and swxor2 rises 18 edges after rst deasserts.
